// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin FIFO arbiter.
//   ARB_STATE_t   : arbiter state (IDLE / GRANT)
//   FIFO_ENTRY_t  : one requester-FIFO entry as carried on the shared channel
//   ARB_NUM_REQ   : default number of requester FIFOs
//   ARB_BURST_MAX : default maximum pops per grant
package fifo_rr_arbiter_pkg;

    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_BURST_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } ARB_STATE_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] data;
    } FIFO_ENTRY_t;

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Bundle of the requester-FIFO pop interface and the registered output stage.
//   fifo_empty / fifo_data : per-FIFO empty flag and head entry (into arbiter)
//   fifo_rd_en             : per-FIFO pop strobe (from arbiter)
//   out_valid/out_data/out_src, out_ready : valid/ready output stage
//   busy                   : arbiter currently holds a grant
// master = arbiter side, slave = FIFO bank + downstream consumer side.
interface fifo_rr_arbiter_if
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        fifo_empty;
    FIFO_ENTRY_t [NUM_REQ-1:0] fifo_data;
    logic [NUM_REQ-1:0]        fifo_rd_en;
    logic                      out_valid;
    FIFO_ENTRY_t               out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      busy;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_rd_en, out_valid, out_data, out_src, busy
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/fifo_rr_arbiter_rr_grant_pick.sv
// Combinational round-robin picker.
//   req_i        : request vector, one bit per requester
//   last_owner_i : index that held the previous grant
//   any_req_o    : at least one request is pending
//   pick_o       : first requesting index scanning cyclically from last_owner_i+1
module rr_grant_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int N     = ARB_NUM_REQ,
    parameter int SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SRC_W-1:0] last_owner_i,
    output logic             any_req_o,
    output logic [SRC_W-1:0] pick_o
);

    // Scan from the farthest candidate down to the nearest so the nearest
    // requester after last_owner_i overwrites the others. The wrap is a
    // subtraction rather than a power-of-2 mask so any N works.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned (which would infer a latch).
        any_req_o = |req_i;
        pick_o    = '0;
        idx       = 0;
        for (int i = N; i >= 1; i--) begin
            idx = int'(last_owner_i) + i;
            if (idx >= N) idx = idx - N;
            if (req_i[idx]) pick_o = SRC_W'(idx);
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one downstream channel between NUM_REQ FIFOs.
// Grants one FIFO at a time for up to BURST_MAX pops, pops by strobing its
// rd_en (head entry taken the same cycle) and registers the entry, tagged with
// its source index, into a valid/ready output stage.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fifo_rr_arbiter_if.master (FIFO pop side + output stage + busy)
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = ARB_NUM_REQ,
    parameter int BURST_MAX = ARB_BURST_MAX,
    parameter int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rr_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    ARB_STATE_t       state_q, state_d;
    logic [SRC_W-1:0] owner_q, owner_d;
    logic [SRC_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             out_valid_q, out_valid_d;
    FIFO_ENTRY_t      out_data_q, out_data_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;

    logic             any_req;
    logic [SRC_W-1:0] pick;
    logic             stage_free;
    logic             pop;

    rr_grant_pick #(
        .N     (NUM_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req_i        (~bus.fifo_empty),
        .last_owner_i (last_owner_q),
        .any_req_o    (any_req),
        .pick_o       (pick)
    );

    // The output register can take a new entry when empty or being drained.
    assign stage_free = ~out_valid_q | bus.out_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        pop          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // A stalled stage freezes the grant, even if the owner drains.
                if (stage_free) begin
                    if (bus.fifo_empty[owner_q]) begin
                        last_owner_d = owner_q;
                        state_d      = IDLE;
                    end else begin
                        pop         = 1'b1;
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        if (burst_cnt_q == CNT_W'(BURST_MAX - 1)) begin
                            last_owner_d = owner_q;
                            burst_cnt_d  = '0;
                            state_d      = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.fifo_data[owner_q];
            out_src_d   = owner_q;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= SRC_W'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            // NOTE: the data register is reset too, so out_data is a defined
            // zero after reset rather than stale contents.
            out_data_q   <= '{default: '0};
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    // Pop strobe is one-hot on the owner; gating with rst keeps a FIFO from
    // losing its head while the arbiter is being reset.
    assign bus.fifo_rd_en = (pop && !rst) ? (NUM_REQ'(1) << owner_q) : '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.busy       = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed testbench for fifo_rr_arbiter (NUM_REQ=4, BURST_MAX=4).
// Requester FIFOs are modelled as queues; outputs are sampled 1-2 time units
// after the rising edge, pop strobes are captured on the falling edge.
module tb_fifo_rr_arbiter;
    import fifo_rr_arbiter_pkg::*;

    localparam int NR = 4;

    logic clk;
    logic rst;

    fifo_rr_arbiter_if #(.NUM_REQ(NR)) bus ();

    fifo_rr_arbiter #(
        .NUM_REQ   (NR),
        .BURST_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    FIFO_ENTRY_t fq [NR][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic FIFO_ENTRY_t mk(input logic [3:0] t, input logic [15:0] d);
        FIFO_ENTRY_t e;
        e.tag  = t;
        e.data = d;
        return e;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NR; i++) begin
            bus.fifo_empty[i] = (fq[i].size() == 0);
            bus.fifo_data[i]  = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic push(input int i, input FIFO_ENTRY_t e);
        fq[i].push_back(e);
        refresh();
    endtask

    // One clock cycle: capture pop strobes before the edge, check the pop
    // invariants, then retire popped entries from the FIFO model.
    task automatic tick();
        logic [NR-1:0] rd_s, emp_s;
        logic          bad;
        @(negedge clk);
        rd_s  = bus.fifo_rd_en;
        emp_s = bus.fifo_empty;
        bad   = ((rd_s & emp_s) != 0) || ($countones(rd_s) > 1) ||
                ((rd_s != 0) && ((bus.out_valid && !bus.out_ready) || !bus.busy || rst));
        check("rd_invariant", 32'(bad), 32'(0));
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (rd_s[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        refresh();
        #1;
    endtask

    // FIFO2 burst expectations, one entry per cycle after the request.
    logic [3:0]  t2_rd [9] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
    logic        t2_v  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t2_b  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] t2_d  [9] = '{16'h0, 16'h000A, 16'h000B, 16'h000C, 16'h000D,
                               16'h0, 16'h000E, 16'h000F, 16'h0};

    // All-four-FIFO round: delivery order and payloads.
    logic [3:0]  t3_s [8] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    logic [15:0] t3_d [8] = '{16'h0C00, 16'h0C01, 16'h0C10, 16'h0C11,
                              16'h0C20, 16'h0C21, 16'h0C30, 16'h0C31};

    initial begin
        FIFO_ENTRY_t got_e [8];
        logic [3:0]  got_s [8];
        int          n_got;

        rst           = 1'b1;
        bus.out_ready = 1'b1;
        refresh();
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_busy",      32'(bus.busy),      32'(0));
        check("rst_rd_en",     32'(bus.fifo_rd_en), 32'(0));
        check("rst_out_data",  32'(bus.out_data),  32'(0));
        check("rst_out_src",   32'(bus.out_src),   32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // All FIFOs empty: nothing happens.
        repeat (20) begin
            tick();
            check("empty_quiet", 32'({bus.busy, bus.fifo_rd_en, bus.out_valid}), 32'(0));
        end

        // FIFO2 alone with A..F: burst of 4, bubble, then E,F.
        for (int j = 0; j < 6; j++) push(2, mk(4'd2, 16'h000A + 16'(j)));
        #1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("t2_rd_en",  32'(bus.fifo_rd_en), 32'(t2_rd[k]));
            check("t2_valid",  32'(bus.out_valid),  32'(t2_v[k]));
            check("t2_busy",   32'(bus.busy),       32'(t2_b[k]));
            if (t2_v[k]) begin
                check("t2_data", 32'(bus.out_data), 32'(mk(4'd2, t2_d[k])));
                check("t2_src",  32'(bus.out_src),  32'(2));
            end
        end

        // Reset so last_owner restarts at NUM_REQ-1 and requester 0 wins first.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;

        // Two entries in every FIFO: grants 0,1,2,3, each released on empty.
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < 2; j++)
                push(i, mk(4'(i), 16'h0C00 | 16'(i << 4) | 16'(j)));
        #1;
        n_got = 0;
        repeat (18) begin
            tick();
            if (bus.out_valid && bus.out_ready) begin
                if (n_got < 8) begin
                    got_e[n_got] = bus.out_data;
                    got_s[n_got] = 4'(bus.out_src);
                end
                n_got++;
            end
        end
        check("t3_count", 32'(n_got), 32'(8));
        for (int i = 0; i < 8; i++) begin
            check("t3_src",  32'(got_s[i]), 32'(t3_s[i]));
            check("t3_data", 32'(got_e[i]), 32'(mk(t3_s[i], t3_d[i])));
        end
        check("t3_idle", 32'(bus.busy), 32'(0));

        // FIFO0 with 3 entries, downstream stalls after the first entry.
        for (int j = 0; j < 3; j++) push(0, mk(4'd0, 16'hD000 + 16'(j)));
        #1;
        tick();
        check("t4_first_pop", 32'(bus.fifo_rd_en), 32'(4'h1));
        tick();
        check("t4_first_valid", 32'(bus.out_valid), 32'(1));
        check("t4_first_data",  32'(bus.out_data),  32'(mk(4'd0, 16'hD000)));
        bus.out_ready = 1'b0;
        #1;
        check("t4_stall_rd", 32'(bus.fifo_rd_en), 32'(0));
        repeat (4) begin
            tick();
            check("t4_hold_valid", 32'(bus.out_valid),  32'(1));
            check("t4_hold_data",  32'(bus.out_data),   32'(mk(4'd0, 16'hD000)));
            check("t4_hold_rd",    32'(bus.fifo_rd_en), 32'(0));
            check("t4_hold_busy",  32'(bus.busy),       32'(1));
        end
        check("t4_single_pop", 32'(fq[0].size()), 32'(2));
        bus.out_ready = 1'b1;
        #1;
        check("t4_resume", 32'(bus.fifo_rd_en), 32'(4'h1));
        tick();
        check("t4_second_data", 32'(bus.out_data),   32'(mk(4'd0, 16'hD001)));
        check("t4_second_rd",   32'(bus.fifo_rd_en), 32'(4'h1));
        tick();
        check("t4_third_data", 32'(bus.out_data),   32'(mk(4'd0, 16'hD002)));
        check("t4_empty_rd",   32'(bus.fifo_rd_en), 32'(0));
        tick();
        check("t4_idle", 32'(bus.busy), 32'(0));

        // Make FIFO3 the last owner, then FIFO0 and FIFO3 both request.
        push(3, mk(4'd3, 16'hE000));
        #1;
        tick();
        check("t5_grant3", 32'(bus.fifo_rd_en), 32'(4'h8));
        tick();
        check("t5_w_src", 32'(bus.out_src), 32'(3));
        tick();
        check("t5_idle", 32'({bus.busy, bus.fifo_rd_en}), 32'(0));
        push(0, mk(4'd0, 16'hE001));
        push(3, mk(4'd3, 16'hE002));
        #1;
        tick();
        check("t5_wrap_rd", 32'(bus.fifo_rd_en), 32'(4'h1));
        tick();
        check("t5_y_src",  32'(bus.out_src),  32'(0));
        check("t5_y_data", 32'(bus.out_data), 32'(mk(4'd0, 16'hE001)));
        tick();
        check("t5_bubble", 32'(bus.busy), 32'(0));
        tick();
        check("t5_next_rd", 32'(bus.fifo_rd_en), 32'(4'h8));
        tick();
        check("t5_z_src",  32'(bus.out_src),  32'(3));
        check("t5_z_data", 32'(bus.out_data), 32'(mk(4'd3, 16'hE002)));
        tick();
        check("t5_idle_end", 32'(bus.busy), 32'(0));

        // Reset in the middle of a FIFO2 burst while FIFO1 and FIFO3 wait.
        for (int j = 0; j < 4; j++) push(2, mk(4'd2, 16'hF000 + 16'(j)));
        #1;
        tick();
        check("t6_grant2", 32'(bus.fifo_rd_en), 32'(4'h4));
        tick();
        check("t6_valid_before", 32'(bus.out_valid), 32'(1));
        push(1, mk(4'd1, 16'hF100));
        push(3, mk(4'd3, 16'hF300));
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(bus.out_valid),  32'(0));
        check("t6_async_busy",  32'(bus.busy),       32'(0));
        check("t6_async_rd",    32'(bus.fifo_rd_en), 32'(0));
        check("t6_async_data",  32'(bus.out_data),   32'(0));
        tick();
        check("t6_no_pop_in_rst", 32'(fq[2].size()), 32'(3));
        check("t6_rst_valid",     32'(bus.out_valid), 32'(0));
        rst = 1'b0;
        #1;
        check("t6_post_idle", 32'(bus.busy), 32'(0));
        tick();
        check("t6_lowest_rd", 32'(bus.fifo_rd_en), 32'(4'h2));
        tick();
        check("t6_lowest_src",  32'(bus.out_src),  32'(1));
        check("t6_lowest_data", 32'(bus.out_data), 32'(mk(4'd1, 16'hF100)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
